// File: rtl/model_tensor_fixed_transmitter_pkg.sv
// Shared definitions for the tensor transmitter slice.
// Holds the FSM state encoding and the zero/one constants used to size
// literals for the index counters and the data path.
package model_tensor_fixed_transmitter_pkg;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    ISSUE_STATE   = 2'd1,
    WAIT_STATE    = 2'd2,
    ENDER_STATE   = 2'd3
  } state_t;

  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;
  localparam logic [63:0] ZERO_DATA    = 64'd0;
  localparam logic [63:0] ONE_DATA     = 64'd1;

endpackage

// File: rtl/model_tensor_fixed_buffer.sv
// Element buffer for the tensor transmitter.
// One write port and one registered read port. A read and a write of the
// same address in the same cycle returns the previous contents.
// Ports:
//   clk, rst                       clock, async active-high reset (read register only)
//   write_enable/address/data      write port
//   read_enable, read_address      read request; data appears on the next cycle
//   read_data                      registered read data, holds between reads
module model_tensor_fixed_buffer
  import model_tensor_fixed_transmitter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int ADDRESS_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic [ADDRESS_SIZE-1:0] write_address,
  input  logic [DATA_SIZE-1:0]    write_data,
  input  logic                    read_enable,
  input  logic [ADDRESS_SIZE-1:0] read_address,
  output logic [DATA_SIZE-1:0]    read_data
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam logic [DATA_SIZE-1:0] D_ZERO = DATA_SIZE'(ZERO_DATA);

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];
  logic [DATA_SIZE-1:0] read_data_d;
  logic [DATA_SIZE-1:0] read_data_q;

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  // Next read value: new word on a read, otherwise hold.
  always_comb begin
    read_data_d = read_data_q;
    if (read_enable) begin
      read_data_d = mem[read_address];
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Read data register; sampling mem here sees the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= D_ZERO;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/model_tensor_fixed_transmitter.sv
// Buffered tensor source: loaded through a write port, then on START streams
// a SIZE_I x SIZE_J x SIZE_K tensor in row-major order, one element per NEXT.
// Each element carries I/J/K framing pulses for the tensor arithmetic blocks.
// Ports:
//   CLK, RST                  clock, async active-high reset
//   START, SIZE_*_IN          stream request and dimensions (sampled when idle)
//   NEXT                      consumer request for the following element
//   WRITE_*                   buffer load port, usable in any state
//   DATA_OUT, DATA_OUT_*_ENABLE  element and one-cycle framing pulses
//   READY                     one-cycle pulse at stream end
//   ERROR                     size overflow flag
// Optional feature: define MODEL_TENSOR_TRANSMITTER_BOUNDS_CHECK_EN to reject
// tensors larger than the buffer (ERROR set, READY pulses, nothing streamed).
module model_tensor_fixed_transmitter
  import model_tensor_fixed_transmitter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int ADDRESS_SIZE = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    NEXT,
  input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_K_IN,
  input  logic                    WRITE_ENABLE,
  input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
  input  logic [DATA_SIZE-1:0]    WRITE_DATA,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic                    DATA_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    ERROR
);

  localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);
  localparam logic [DATA_SIZE-1:0]    D_ONE  = DATA_SIZE'(ONE_DATA);
  localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [ADDRESS_SIZE-1:0] A_ZERO = ADDRESS_SIZE'(ZERO_CONTROL);
  localparam logic [ADDRESS_SIZE-1:0] A_ONE  = ADDRESS_SIZE'(ONE_CONTROL);

  state_t                  state_d, state_q;
  logic [DATA_SIZE-1:0]    size_i_d, size_i_q, size_j_d, size_j_q, size_k_d, size_k_q;
  logic [CONTROL_SIZE-1:0] i_d, i_q, j_d, j_q, k_d, k_q;
  logic [ADDRESS_SIZE-1:0] address_d, address_q;
  logic                    i_en_d, i_en_q, j_en_d, j_en_q, k_en_d, k_en_q;
  logic                    ready_d, ready_q, error_d, error_q;
  logic                    size_zero_s, size_over_s;
  logic                    i_last_s, j_last_s, k_last_s;
  logic                    read_enable_s;

  assign size_zero_s = (SIZE_I_IN == D_ZERO) || (SIZE_J_IN == D_ZERO) || (SIZE_K_IN == D_ZERO);

`ifdef MODEL_TENSOR_TRANSMITTER_BOUNDS_CHECK_EN
  localparam int NW = ADDRESS_SIZE + 1;
  localparam int PW = 3 * NW;
  localparam logic [DATA_SIZE-1:0] DEPTH = D_ONE << ADDRESS_SIZE;

  // Any single dimension above the depth already overflows; otherwise each
  // fits in NW bits and the product cannot overflow PW bits.
  function automatic logic exceeds_depth(input logic [DATA_SIZE-1:0] a,
                                         input logic [DATA_SIZE-1:0] b,
                                         input logic [DATA_SIZE-1:0] c);
    logic [PW-1:0] prod;
    logic          over;
    prod = PW'(NW'(a)) * PW'(NW'(b)) * PW'(NW'(c));
    if ((a > DEPTH) || (b > DEPTH) || (c > DEPTH)) begin
      over = 1'b1;
    end else begin
      over = (prod > PW'(DEPTH));
    end
    return over;
  endfunction

  assign size_over_s = exceeds_depth(SIZE_I_IN, SIZE_J_IN, SIZE_K_IN);
`else
  assign size_over_s = 1'b0;
`endif

  assign i_last_s = (i_q == CONTROL_SIZE'(size_i_q - D_ONE));
  assign j_last_s = (j_q == CONTROL_SIZE'(size_j_q - D_ONE));
  assign k_last_s = (k_q == CONTROL_SIZE'(size_k_q - D_ONE));
  assign read_enable_s = (state_q == ISSUE_STATE);

  // Next-state, index advance and output pulse computation.
  always_comb begin
    state_d   = state_q;
    size_i_d  = size_i_q;
    size_j_d  = size_j_q;
    size_k_d  = size_k_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    address_d = address_q;
    i_en_d    = 1'b0;
    j_en_d    = 1'b0;
    k_en_d    = 1'b0;
    ready_d   = 1'b0;
    error_d   = error_q;
    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          error_d = 1'b0;
          if (size_zero_s) begin
            state_d = ENDER_STATE;
          end else if (size_over_s) begin
            error_d = 1'b1;
            state_d = ENDER_STATE;
          end else begin
            size_i_d  = SIZE_I_IN;
            size_j_d  = SIZE_J_IN;
            size_k_d  = SIZE_K_IN;
            i_d       = C_ZERO;
            j_d       = C_ZERO;
            k_d       = C_ZERO;
            address_d = A_ZERO;
            state_d   = ISSUE_STATE;
          end
        end else begin
          state_d = STARTER_STATE;
        end
      end
      ISSUE_STATE: begin
        k_en_d  = 1'b1;
        j_en_d  = (k_q == C_ZERO);
        i_en_d  = (j_q == C_ZERO) && (k_q == C_ZERO);
        state_d = WAIT_STATE;
      end
      WAIT_STATE: begin
        if (NEXT) begin
          if (i_last_s && j_last_s && k_last_s) begin
            state_d = ENDER_STATE;
          end else begin
            // Row-major advance: k fastest, carrying into j then i.
            if (!k_last_s) begin
              k_d = k_q + C_ONE;
            end else begin
              k_d = C_ZERO;
              if (!j_last_s) begin
                j_d = j_q + C_ONE;
              end else begin
                j_d = C_ZERO;
                i_d = i_q + C_ONE;
              end
            end
            address_d = address_q + A_ONE;
            state_d   = ISSUE_STATE;
          end
        end else begin
          state_d = WAIT_STATE;
        end
      end
      ENDER_STATE: begin
        ready_d = 1'b1;
        state_d = STARTER_STATE;
      end
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= STARTER_STATE;
      size_i_q  <= D_ZERO;
      size_j_q  <= D_ZERO;
      size_k_q  <= D_ZERO;
      i_q       <= C_ZERO;
      j_q       <= C_ZERO;
      k_q       <= C_ZERO;
      address_q <= A_ZERO;
      i_en_q    <= 1'b0;
      j_en_q    <= 1'b0;
      k_en_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_i_q  <= size_i_d;
      size_j_q  <= size_j_d;
      size_k_q  <= size_k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      address_q <= address_d;
      i_en_q    <= i_en_d;
      j_en_q    <= j_en_d;
      k_en_q    <= k_en_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  // DATA_OUT is the buffer's read register, loaded only in ISSUE_STATE.
  model_tensor_fixed_buffer #(
    .DATA_SIZE   (DATA_SIZE),
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_buffer (
    .clk          (CLK),
    .rst          (RST),
    .write_enable (WRITE_ENABLE),
    .write_address(WRITE_ADDRESS),
    .write_data   (WRITE_DATA),
    .read_enable  (read_enable_s),
    .read_address (address_q),
    .read_data    (DATA_OUT)
  );

  assign DATA_OUT_I_ENABLE = i_en_q;
  assign DATA_OUT_J_ENABLE = j_en_q;
  assign DATA_OUT_K_ENABLE = k_en_q;
  assign READY             = ready_q;
  assign ERROR             = error_q;

endmodule

// File: tb/tb_model_tensor_fixed_transmitter.sv
// Self-checking bench for model_tensor_fixed_transmitter.
// u_dut1 uses an 8-bit address; u_dut2 uses a 2-bit address for the
// overflow / wrap scenario. Both share clock, reset, START, NEXT and sizes.
module tb_model_tensor_fixed_transmitter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START, NEXT;
  logic [63:0] size_i, size_j, size_k;
  logic        we1, we2;
  logic [7:0]  wa1;
  logic [1:0]  wa2;
  logic [63:0] wd1, wd2;
  logic        rdy1, ien1, jen1, ken1, err1;
  logic        rdy2, ien2, jen2, ken2, err2;
  logic [63:0] dout1, dout2;
  logic        use2;
  logic        rdy_s, ien_s, jen_s, ken_s, err_s;
  logic [63:0] dout_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        start;
    logic        next;
    logic [63:0] exp_d;
    logic        exp_i, exp_j, exp_k, exp_rdy;
  } vec_t;

  vec_t        vecs [19];
  logic [63:0] exp_mem [8];

  always #5 CLK = ~CLK;

  model_tensor_fixed_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(64), .ADDRESS_SIZE(8)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(START), .READY(rdy1), .NEXT(NEXT),
    .SIZE_I_IN(size_i), .SIZE_J_IN(size_j), .SIZE_K_IN(size_k),
    .WRITE_ENABLE(we1), .WRITE_ADDRESS(wa1), .WRITE_DATA(wd1),
    .DATA_OUT_I_ENABLE(ien1), .DATA_OUT_J_ENABLE(jen1), .DATA_OUT_K_ENABLE(ken1),
    .DATA_OUT(dout1), .ERROR(err1)
  );

  model_tensor_fixed_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(64), .ADDRESS_SIZE(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .START(START), .READY(rdy2), .NEXT(NEXT),
    .SIZE_I_IN(size_i), .SIZE_J_IN(size_j), .SIZE_K_IN(size_k),
    .WRITE_ENABLE(we2), .WRITE_ADDRESS(wa2), .WRITE_DATA(wd2),
    .DATA_OUT_I_ENABLE(ien2), .DATA_OUT_J_ENABLE(jen2), .DATA_OUT_K_ENABLE(ken2),
    .DATA_OUT(dout2), .ERROR(err2)
  );

  assign rdy_s  = use2 ? rdy2  : rdy1;
  assign ien_s  = use2 ? ien2  : ien1;
  assign jen_s  = use2 ? jen2  : jen1;
  assign ken_s  = use2 ? ken2  : ken1;
  assign err_s  = use2 ? err2  : err1;
  assign dout_s = use2 ? dout2 : dout1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write1(input int a, input logic [63:0] d);
    we1 = 1'b1; wa1 = a[7:0]; wd1 = d;
    tick();
    we1 = 1'b0;
  endtask

  task automatic write2(input int a, input logic [63:0] d);
    we2 = 1'b1; wa2 = a[1:0]; wd2 = d;
    tick();
    we2 = 1'b0;
  endtask

  task automatic start_stream(input int si, input int sj, input int sk);
    size_i = 64'(si); size_j = 64'(sj); size_k = 64'(sk);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Wait (bounded) for the element's K pulse, check it, optionally hold, then request the next.
  task automatic take_elem(input string name, input logic [63:0] exp_d,
                           input logic exp_i, input logic exp_j, input int hold);
    int n = 0;
    while (ken_s !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, " k_en"}, 128'(ken_s), 128'(1'b1));
    check({name, " data/i/j"}, 128'({dout_s, ien_s, jen_s}), 128'({exp_d, exp_i, exp_j}));
    for (int d = 0; d < hold; d++) begin
      tick();
      check({name, " hold"}, 128'({dout_s, ien_s, jen_s, ken_s}), 128'({exp_d, 3'b000}));
    end
    NEXT = 1'b1;
    tick();
    NEXT = 1'b0;
  endtask

  // Called right after the last NEXT edge: READY must appear exactly one cycle later, for one cycle.
  task automatic expect_ready(input string name);
    check({name, " rdy-early"}, 128'(rdy_s), 128'(1'b0));
    tick();
    check({name, " rdy"}, 128'({rdy_s, ien_s, jen_s, ken_s}), 128'(4'b1000));
    tick();
    check({name, " rdy-end"}, 128'(rdy_s), 128'(1'b0));
  endtask

  initial begin
    logic [63:0] last_d;
    int          e;
    int          seen;

    RST = 1'b1; START = 1'b0; NEXT = 1'b0; use2 = 1'b0;
    size_i = 64'd0; size_j = 64'd0; size_k = 64'd0;
    we1 = 1'b0; wa1 = 8'd0; wd1 = 64'd0;
    we2 = 1'b0; wa2 = 2'd0; wd2 = 64'd0;
    tick(); tick();
    RST = 1'b0;
    check("reset dut1", 128'({dout1, ien1, jen1, ken1, rdy1, err1}), 128'(0));
    check("reset dut2", 128'({dout2, ien2, jen2, ken2, rdy2, err2}), 128'(0));

    for (int a = 0; a < 8; a++) begin
      write1(a, 64'(a));
      exp_mem[a] = 64'(a);
    end

    // 2x2x2 with NEXT held high: element e appears on record 2e+1, READY on record 17.
    last_d = 64'd0;
    for (int r = 0; r < 19; r++) begin
      vecs[r].start   = (r == 0);
      vecs[r].next    = (r != 0);
      vecs[r].exp_rdy = (r == 17);
      if ((r % 2 == 1) && (r <= 15)) begin
        e = (r - 1) / 2;
        last_d = 64'(e);
        vecs[r].exp_k = 1'b1;
        vecs[r].exp_j = (e % 2 == 0);
        vecs[r].exp_i = (e % 4 == 0);
      end else begin
        vecs[r].exp_k = 1'b0;
        vecs[r].exp_j = 1'b0;
        vecs[r].exp_i = 1'b0;
      end
      vecs[r].exp_d = last_d;
    end
    size_i = 64'd2; size_j = 64'd2; size_k = 64'd2;
    for (int r = 0; r < 19; r++) begin
      START = vecs[r].start;
      NEXT  = vecs[r].next;
      tick();
      check($sformatf("vec%0d", r),
            128'({dout_s, ien_s, jen_s, ken_s, rdy_s}),
            128'({vecs[r].exp_d, vecs[r].exp_i, vecs[r].exp_j, vecs[r].exp_k, vecs[r].exp_rdy}));
    end
    START = 1'b0; NEXT = 1'b0;
    check("err after 2x2x2", 128'(err_s), 128'(1'b0));

    // 1x1x3 with NEXT delayed 5 cycles per element.
    start_stream(1, 1, 3);
    take_elem("slow e0", 64'd0, 1'b1, 1'b1, 5);
    take_elem("slow e1", 64'd1, 1'b0, 1'b0, 5);
    take_elem("slow e2", 64'd2, 1'b0, 1'b0, 5);
    expect_ready("slow");

    // Zero-size dimension: READY two cycles after START, no framing.
    start_stream(2, 0, 2);
    check("zero n+1", 128'({rdy_s, ien_s, jen_s, ken_s}), 128'(4'b0000));
    tick();
    check("zero n+2", 128'({rdy_s, ien_s, jen_s, ken_s}), 128'(4'b1000));
    tick();
    check("zero n+3", 128'(rdy_s), 128'(1'b0));

    // Write to address 1 during the cycle element 1 is issued: old data out.
    start_stream(1, 1, 2);
    take_elem("rbw e0", 64'd0, 1'b1, 1'b1, 0);
    write1(1, 64'hAA);
    exp_mem[1] = 64'hAA;
    take_elem("rbw e1", 64'd1, 1'b0, 1'b0, 0);
    expect_ready("rbw");
    start_stream(1, 1, 2);
    take_elem("rerun e0", 64'd0, 1'b1, 1'b1, 0);
    take_elem("rerun e1", 64'hAA, 1'b0, 1'b0, 0);
    expect_ready("rerun");

    // Reset while element 3 is on the outputs.
    start_stream(2, 2, 2);
    take_elem("pre e0", exp_mem[0], 1'b1, 1'b1, 0);
    take_elem("pre e1", exp_mem[1], 1'b0, 1'b0, 0);
    take_elem("pre e2", exp_mem[2], 1'b0, 1'b1, 0);
    seen = 0;
    while (ken_s !== 1'b1 && seen < 20) begin
      tick();
      seen++;
    end
    check("pre e3", 128'({dout_s, ken_s}), 128'({exp_mem[3], 1'b1}));
    RST = 1'b1;
    #1;
    check("async reset", 128'({dout_s, ien_s, jen_s, ken_s, rdy_s, err_s}), 128'(0));
    tick(); tick();
    RST = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rdy_s === 1'b1) seen++;
    end
    check("no ready after reset", 128'(seen), 128'(0));
    start_stream(2, 2, 2);
    for (int k = 0; k < 8; k++) begin
      take_elem($sformatf("restart e%0d", k), exp_mem[k], (k % 4 == 0), (k % 2 == 0), 0);
    end
    expect_ready("restart");

    // Narrow-address instance: 2x2x2 exceeds a 4-entry buffer.
    for (int a = 0; a < 4; a++) write2(a, 64'h10 + 64'(a));
    use2 = 1'b1;
    start_stream(2, 2, 2);
`ifdef MODEL_TENSOR_TRANSMITTER_BOUNDS_CHECK_EN
    check("bound n+1", 128'({err_s, rdy_s, ien_s, jen_s, ken_s}), 128'(5'b10000));
    tick();
    check("bound n+2", 128'({err_s, rdy_s, ien_s, jen_s, ken_s}), 128'(5'b11000));
    tick();
    check("bound n+3", 128'({err_s, rdy_s, ien_s, jen_s, ken_s}), 128'(5'b10000));
`else
    for (int k = 0; k < 8; k++) begin
      take_elem($sformatf("wrap e%0d", k), 64'h10 + 64'(k % 4), (k % 4 == 0), (k % 2 == 0), 0);
    end
    expect_ready("wrap");
    check("wrap err", 128'(err_s), 128'(1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
